// File: rtl/stim_sequencer.sv
// Vector player: plays a writable memory of {rpt, obs, data} entries onto DUT-facing outputs.
// Supports a programmable length, loop mode, per-entry repeat, stall and abort, plus done/wrap status.
module stim_sequencer #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 26,
  parameter int RPT_W  = 4,
  parameter int WRAP_W = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int EW = RPT_W + 1 + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [EW-1:0]     wr_data,
  input  logic              start,
  input  logic              abort,
  input  logic              loop_en,
  input  logic [AW-1:0]     last_idx,
  input  logic              stall,
  output logic [DATA_W-1:0] vec_out,
  output logic              obs_out,
  output logic [AW-1:0]     pc_out,
  output logic              busy,
  output logic              done,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_MAX  = AW'(DEPTH - 1);

  state_t              state_reg, state_next;
  logic [EW-1:0]       mem [DEPTH];
  logic [AW-1:0]       pc_reg, pc_next;
  logic [AW-1:0]       last_reg, last_next;
  logic [AW-1:0]       last_clamped, load_idx;
  logic [RPT_W-1:0]    rcnt_reg, rcnt_next;
  logic [DATA_W-1:0]   vec_reg, vec_next;
  logic                obs_reg, obs_next;
  logic                loop_reg, loop_next;
  logic [WRAP_W-1:0]   wrap_reg, wrap_next;
  logic [EW-1:0]       load_entry;

  // Out-of-range write addresses are dropped rather than aliased.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < DEPTH_EXT)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    last_clamped = (last_idx > LAST_MAX) ? LAST_MAX : last_idx;
    load_idx     = (state_reg == RUN && pc_reg < last_reg) ? pc_reg + AW'(1) : '0;
    load_entry   = mem[load_idx];
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    last_next  = last_reg;
    rcnt_next  = rcnt_reg;
    vec_next   = vec_reg;
    obs_next   = obs_reg;
    loop_next  = loop_reg;
    wrap_next  = wrap_reg;

    if (abort) begin
      state_next = IDLE;
      pc_next    = '0;
      rcnt_next  = '0;
      vec_next   = '0;
      obs_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_next = RUN;
            pc_next    = '0;
            vec_next   = load_entry[DATA_W-1:0];
            obs_next   = load_entry[DATA_W];
            rcnt_next  = load_entry[EW-1:DATA_W+1];
            loop_next  = loop_en;
            last_next  = last_clamped;
            wrap_next  = '0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (rcnt_reg != '0) begin
              rcnt_next = rcnt_reg - RPT_W'(1);
            end else if (pc_reg < last_reg || loop_reg) begin
              // load_idx already selects pc+1 or entry 0 on wrap.
              pc_next   = load_idx;
              vec_next  = load_entry[DATA_W-1:0];
              obs_next  = load_entry[DATA_W];
              rcnt_next = load_entry[EW-1:DATA_W+1];
              if (pc_reg >= last_reg && wrap_reg != '1) begin
                wrap_next = wrap_reg + WRAP_W'(1);
              end
            end else begin
              state_next = DONE;
              obs_next   = 1'b0;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      last_reg  <= '0;
      rcnt_reg  <= '0;
      vec_reg   <= '0;
      obs_reg   <= 1'b0;
      loop_reg  <= 1'b0;
      wrap_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      last_reg  <= last_next;
      rcnt_reg  <= rcnt_next;
      vec_reg   <= vec_next;
      obs_reg   <= obs_next;
      loop_reg  <= loop_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign vec_out  = vec_reg;
  assign obs_out  = obs_reg;
  assign pc_out   = pc_reg;
  assign busy     = (state_reg == RUN);
  assign done     = (state_reg == DONE);
  assign wrap_cnt = wrap_reg;

endmodule

// File: tb/tb_stim_sequencer.sv
// Bench for stim_sequencer: expected playback is derived from a per-cycle entry list built from
// the model memory, indexed by the number of non-stalled edges since start.
module tb_stim_sequencer;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 26;
  localparam int RPT_W  = 4;
  localparam int WRAP_W = 2;
  localparam int AW     = 5;
  localparam int EW     = RPT_W + 1 + DATA_W;
  localparam int WMAX   = (1 << WRAP_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [EW-1:0]     wr_data = '0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              loop_en = 1'b0;
  logic [AW-1:0]     last_idx = '0;
  logic              stall = 1'b0;
  logic [DATA_W-1:0] vec_out;
  logic              obs_out;
  logic [AW-1:0]     pc_out;
  logic              busy;
  logic              done;
  logic [WRAP_W-1:0] wrap_cnt;

  stim_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RPT_W(RPT_W), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .loop_en(loop_en), .last_idx(last_idx), .stall(stall),
    .vec_out(vec_out), .obs_out(obs_out), .pc_out(pc_out), .busy(busy), .done(done),
    .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] m_data [DEPTH];
  logic         m_obs  [DEPTH];
  int           m_rpt  [DEPTH];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      $error("%s miscompare", tag);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int rpt, input bit obs, input logic [127:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = {RPT_W'(rpt), obs, d};
    tick;
    wr_en = 1'b0;
    if (a < DEPTH) begin
      m_data[a] = d; m_obs[a] = obs; m_rpt[a] = rpt;
    end
  endtask

  task automatic chk_idle(input string tag, input int w);
    chk({tag, ".vec"},  vec_out, 128'(0));
    chk({tag, ".obs"},  obs_out, 128'(0));
    chk({tag, ".pc"},   pc_out, 128'(0));
    chk({tag, ".busy"}, busy, 128'(0));
    chk({tag, ".done"}, done, 128'(0));
    chk({tag, ".wrap"}, wrap_cnt, 128'(w));
  endtask

  task automatic chk_entry(input string tag, input int idx, input int w);
    chk({tag, ".vec"},  vec_out, m_data[idx]);
    chk({tag, ".obs"},  obs_out, 128'(m_obs[idx]));
    chk({tag, ".pc"},   pc_out, 128'(idx));
    chk({tag, ".busy"}, busy, 128'(1));
    chk({tag, ".done"}, done, 128'(0));
    chk({tag, ".wrap"}, wrap_cnt, 128'(w));
  endtask

  task automatic chk_done(input string tag, input int idx);
    chk({tag, ".vec"},  vec_out, m_data[idx]);
    chk({tag, ".obs"},  obs_out, 128'(0));
    chk({tag, ".busy"}, busy, 128'(0));
    chk({tag, ".done"}, done, 128'(1));
    chk({tag, ".wrap"}, wrap_cnt, 128'(0));
  endtask

  function automatic int wraps(input int k, input int size);
    int w;
    w = k / size;
    return (w > WMAX) ? WMAX : w;
  endfunction

  // Looping runs end with a combined abort+start edge, so the DUT is left in IDLE.
  task automatic run_pass(input string tag, input int l_in, input bit lp, input int ncyc,
                          input logic [63:0] smask, input bit rnd_start);
    int l, size, k, c, extra;
    bit in_run, s;
    int q[$];
    l = (l_in > DEPTH - 1) ? DEPTH - 1 : l_in;
    for (int i = 0; i <= l; i++)
      for (int r = 0; r <= m_rpt[i]; r++) q.push_back(i);
    size = q.size();
    last_idx = AW'(l_in); loop_en = lp; start = 1'b1;
    tick;
    start = 1'b0;
    last_idx = AW'($urandom); loop_en = ~lp;
    k = 0;
    chk_entry({tag, ".start"}, q[0], 0);
    c = 0; extra = 0;
    while (lp ? (c < ncyc) : (extra < 3)) begin
      in_run = lp || (k < size);
      s = (c < 64) ? smask[c] : 1'b0;
      stall = s;
      start = rnd_start && in_run && ($urandom_range(0, 7) == 0);
      tick;
      stall = 1'b0; start = 1'b0;
      if (in_run && !s) k++;
      if (lp || k < size) chk_entry(tag, q[k % size], wraps(k, size));
      else begin
        chk_done(tag, l);
        extra++;
      end
      c++;
    end
    if (lp) begin
      abort = 1'b1; start = 1'b1;
      tick;
      abort = 1'b0; start = 1'b0;
      chk_idle({tag, ".abort"}, wraps(k, size));
    end
  endtask

  initial begin
    // Reset and idle; memory contents must survive reset.
    tick;
    rst = 1'b0;
    wr(0, 0, 1'b1, 128'hA);
    wr(1, 0, 1'b0, 128'hB);
    wr(2, 0, 1'b1, 128'hC);
    rst = 1'b1; start = 1'b1; loop_en = 1'b1;
    tick; tick;
    rst = 1'b0; start = 1'b0; loop_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stall = (i == 2);
      tick;
      chk_idle("idle", 0);
    end
    stall = 1'b0;

    run_pass("basic", 2, 1'b0, 0, 64'h0, 1'b0);

    wr(0, 2, 1'b1, 128'h11);
    wr(1, 0, 1'b0, 128'h22);
    run_pass("rpt_stall", 1, 1'b0, 0, 64'h6, 1'b0);

    wr(0, 0, 1'b0, 128'h5A5A);
    wr(1, 0, 1'b1, 128'hA5A5);
    run_pass("loop_sat", 1, 1'b1, 13, 64'h0, 1'b0);
    tick;
    chk_idle("post_abort", WMAX);

    run_pass("restart", 1, 1'b0, 0, 64'h0, 1'b1);
    run_pass("single_loop", 0, 1'b1, 9, 64'h10, 1'b0);

    for (int i = 0; i < DEPTH; i++)
      wr(i, $urandom_range(0, 2), 1'($urandom), {$urandom, $urandom, $urandom, $urandom});
    wr(27, 3, 1'b1, 128'hDEAD);
    run_pass("clamp31", 31, 1'b0, 0, {$urandom, $urandom} & {$urandom, $urandom}, 1'b1);

    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < DEPTH; i++)
        wr(i, $urandom_range(0, 3), 1'($urandom), {$urandom, $urandom, $urandom, $urandom});
      run_pass($sformatf("rand%0d", p), $urandom_range(0, 31), 1'($urandom), 40,
               {$urandom, $urandom} & {$urandom, $urandom}, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stim_sequencer.md
Name: stim_sequencer

Overview:
- Synthesizable, parametrised vector player for concolic/trace benches.
- Holds a writable vector memory. Each entry carries a data word, an observation flag and a repeat count.
- After start, steps through the memory one entry per advance and drives data and flag onto DUT-facing outputs.
- Adds the following over a fixed testbench player: programmable length, loop mode, per-entry repeat, stall, abort, and done/wrap status.

Parameters:
- DATA_W, 128, width of driven data word.
- DEPTH, 26, number of vector entries.
- RPT_W, 4, width of per-entry repeat field; an entry is held for rpt+1 cycles.
- WRAP_W, 8, width of loop wrap counter (saturating).
- Localparam AW = max(1, clog2(DEPTH)); entry width EW = RPT_W+1+DATA_W, packed {rpt, obs, data}.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  memory write strobe.
- wr_addr  in  AW  write index; writes with wr_addr >= DEPTH are ignored.
- wr_data  in  EW  entry {rpt, obs, data}.
- start  in  1  begin playback; honoured in IDLE or DONE only.
- abort  in  1  stop playback, return to IDLE.
- loop_en  in  1  sampled at start; 1 = wrap to entry 0 after last entry.
- last_idx  in  AW  sampled at start; index of final entry, clamped to DEPTH-1.
- stall  in  1  freeze playback while high (RUN only).
- vec_out  out  DATA_W  current data word.
- obs_out  out  1  current observation flag.
- pc_out  out  AW  index of the entry currently presented.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- wrap_cnt  out  WRAP_W  number of completed wraps, saturating.

Behaviour:
- Reset (synchronous, rst=1 at edge): state IDLE; vec_out=0, obs_out=0, pc_out=0, busy=0, done=0, wrap_cnt=0, repeat counter=0. Memory contents are not reset. rst overrides all other inputs.
- Memory: register array with combinational read. A write lands at the edge. A write to the entry currently presented does not alter vec_out/obs_out until that entry is next loaded.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start at edge E (abort=0):
  - State becomes RUN, pc=0, mem[0] loaded onto outputs at E, and rcnt=mem[0].rpt.
  - loop_en and last_idx are latched; wrap_cnt is cleared to 0.
  - busy=1 and done=0 from E.
- RUN, stall=0:
  - If rcnt>0: decrement rcnt; outputs hold.
  - Otherwise advance:
    - pc<last: pc+1, load that entry.
    - pc==last and loop: pc=0, load mem[0], wrap_cnt+1 (saturate at all-ones).
    - pc==last and no loop: go to DONE.
- RUN, stall=1: pc, rcnt, outputs and wrap_cnt all frozen. Stall has no effect in IDLE/DONE.
- Entering DONE: vec_out holds the last data word, obs_out forced 0, busy=0, done=1. done stays high until start, abort or rst.
- abort=1 in any state: next state IDLE; vec_out=0, obs_out=0, pc_out=0, busy=0, done=0. wrap_cnt holds. abort takes priority over start and stall.
- start while RUN is ignored.
- Simultaneous start+abort: abort wins.
- Cycle count for one non-looping pass: sum over entries 0..last of (rpt+1) cycles with busy=1; done rises on the following edge.
- Special case last_idx=0 with loop: entry 0 replays each wrap, and wrap_cnt increments every rpt+1 cycles.

Test Plan:
- Reset/idle: load 3 entries, hold rst 2 cycles, then idle 5 cycles -> all outputs 0, done=0, busy=0, no memory corruption (read back via playback).
- Basic pass: entries {0,1,0xA},{0,0,0xB},{0,1,0xC}, last_idx=2, loop=0, start -> vec_out A,B,C on consecutive cycles with obs 1,0,1; busy high 3 cycles; then done=1, obs_out=0, vec_out=C held.
- Repeat+stall: entry0 rpt=2 data 0x11, entry1 rpt=0 data 0x22, stall pulsed 2 cycles during entry0 -> 0x11 shown 5 cycles total, then 0x22; pc_out frozen during stall.
- Loop+saturation: WRAP_W=2, last_idx=1, loop=1, all rpt=0, run 12 cycles -> vec alternates entry0/entry1; wrap_cnt 1,2,3 then stays 3.
- Abort/priority: abort mid-RUN at pc=1 together with start -> next cycle IDLE, outputs 0, busy=0; a later start restarts at pc=0 and clears wrap_cnt.
- Boundaries: last_idx=31 with DEPTH=26 -> plays 0..25 then DONE; write with wr_addr=27 ignored; start asserted while RUN -> no restart.
